// File: rtl/game_pkg.sv
// Shared game definitions: state codes, winner codes, datapath widths,
// the fight FSM state type and small arithmetic helpers.
package game_pkg;

    localparam logic [3:0] MAIN_MENU           = 4'b0000;
    localparam logic [3:0] CHARACTER_SELECTION = 4'b0001;
    localparam logic [3:0] FIGHT_STATE         = 4'b0010;
    localparam logic [3:0] END_STATE           = 4'b0011;

    localparam int HEALTH_W = 8;
    localparam int TIMER_W  = 7;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_PREFIGHT,
        FS_FIGHT,
        FS_OVER
    } fight_state_t;

    // Health never wraps: any damage at or above the current health floors it at zero.
    function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] health,
                                                    input logic [HEALTH_W-1:0] damage);
        return (damage >= health) ? '0 : health - damage;
    endfunction

    // Timeout decision: more health wins, equal health is a draw.
    function automatic winner_t compare_winner(input logic [HEALTH_W-1:0] h1,
                                               input logic [HEALTH_W-1:0] h2);
        if (h1 > h2)
            return WIN_P1;
        else if (h2 > h1)
            return WIN_P2;
        else
            return WIN_DRAW;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles.
// The synchronous clear holds the count at zero so the first tick after
// release lands exactly TICK_DIV edges later.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Wrapping counter 0..TICK_DIV-1, parked at zero while cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear || count == LAST)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fight_round_controller.sv
// Runs one fight round: pre-fight countdown, round timer, two health
// counters and the winner decision.
//
//   state       | meaning
//   ------------+---------------------------------------------------
//   FS_IDLE     | waiting for game_state == FIGHT_STATE, prescaler held
//   FS_PREFIGHT | countdown running, hits ignored
//   FS_FIGHT    | hits applied, KO / timeout evaluated
//   FS_OVER     | result latched, game_over high until game_state leaves
//
// Leaving FIGHT_STATE from any active state returns to FS_IDLE but keeps the
// healths, timer and winner so the end screen can still show them.
module fight_round_controller
    import game_pkg::*;
#(
    parameter int TICK_DIV     = 100_000_000,
    parameter int MAX_HEALTH   = 100,
    parameter int ROUND_SEC    = 99,
    parameter int PREFIGHT_SEC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] game_state,
    input  logic       p1_hit_valid,
    input  logic [7:0] p1_hit_damage,
    input  logic       p2_hit_valid,
    input  logic [7:0] p2_hit_damage,
    output logic [7:0] p1_health,
    output logic [7:0] p2_health,
    output logic [6:0] timer_sec,
    output logic [1:0] countdown_sec,
    output logic       fight_active,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);
    localparam logic [TIMER_W-1:0]  TIMER_INIT  = TIMER_W'(ROUND_SEC);
    localparam logic [1:0]          COUNT_INIT  = 2'(PREFIGHT_SEC);

    fight_state_t      state;
    logic              tick;
    logic              in_fight;
    logic [HEALTH_W-1:0] p1_next;
    logic [HEALTH_W-1:0] p2_next;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state == FS_IDLE),
        .tick (tick)
    );

    assign in_fight = (game_state == FIGHT_STATE);

    // Post-hit healths; both players update in the same cycle when both strobe.
    always_comb begin
        p1_next = p1_health;
        p2_next = p2_health;
        if (p1_hit_valid)
            p1_next = sat_sub(p1_health, p1_hit_damage);
        if (p2_hit_valid)
            p2_next = sat_sub(p2_health, p2_hit_damage);
    end

    // Round sequencing with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= FS_IDLE;
            p1_health     <= HEALTH_INIT;
            p2_health     <= HEALTH_INIT;
            timer_sec     <= TIMER_INIT;
            countdown_sec <= COUNT_INIT;
            fight_active  <= 1'b0;
            game_over     <= 1'b0;
            winner        <= WIN_NONE;
        end else if (state == FS_IDLE) begin
            fight_active <= 1'b0;
            game_over    <= 1'b0;
            if (in_fight) begin
                state         <= FS_PREFIGHT;
                p1_health     <= HEALTH_INIT;
                p2_health     <= HEALTH_INIT;
                timer_sec     <= TIMER_INIT;
                countdown_sec <= COUNT_INIT;
                winner        <= WIN_NONE;
            end
        end else if (!in_fight) begin
            state        <= FS_IDLE;
            fight_active <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            case (state)
                FS_PREFIGHT: begin
                    if (tick) begin
                        countdown_sec <= countdown_sec - 2'd1;
                        if (countdown_sec == 2'd1) begin
                            state        <= FS_FIGHT;
                            fight_active <= 1'b1;
                        end
                    end
                end
                FS_FIGHT: begin
                    p1_health <= p1_next;
                    p2_health <= p2_next;
                    if (tick)
                        timer_sec <= timer_sec - TIMER_W'(1);
                    if (p1_next == '0 || p2_next == '0) begin
                        state        <= FS_OVER;
                        fight_active <= 1'b0;
                        game_over    <= 1'b1;
                        if (p1_next == '0 && p2_next == '0)
                            winner <= WIN_DRAW;
                        else if (p2_next == '0)
                            winner <= WIN_P1;
                        else
                            winner <= WIN_P2;
                    end else if (tick && timer_sec == TIMER_W'(1)) begin
                        state        <= FS_OVER;
                        fight_active <= 1'b0;
                        game_over    <= 1'b1;
                        winner       <= compare_winner(p1_next, p2_next);
                    end
                end
                FS_OVER: begin
                    game_over <= 1'b1;
                end
                default: begin
                    state <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fight_round_controller.sv
// Bench for fight_round_controller with a short tick (4 clk per second).
// A table of per-cycle vectors is applied in order; each vector's expected
// outputs go onto a scoreboard queue when driven and are popped after the edge.
module tb_fight_round_controller;
    import game_pkg::*;

    localparam int TICK_DIV     = 4;
    localparam int MAX_HEALTH   = 100;
    localparam int ROUND_SEC    = 5;
    localparam int PREFIGHT_SEC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] game_state;
    logic       p1_hit_valid;
    logic [7:0] p1_hit_damage;
    logic       p2_hit_valid;
    logic [7:0] p2_hit_damage;
    logic [7:0] p1_health;
    logic [7:0] p2_health;
    logic [6:0] timer_sec;
    logic [1:0] countdown_sec;
    logic       fight_active;
    logic       game_over;
    logic [1:0] winner;

    fight_round_controller #(
        .TICK_DIV    (TICK_DIV),
        .MAX_HEALTH  (MAX_HEALTH),
        .ROUND_SEC   (ROUND_SEC),
        .PREFIGHT_SEC(PREFIGHT_SEC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .game_state   (game_state),
        .p1_hit_valid (p1_hit_valid),
        .p1_hit_damage(p1_hit_damage),
        .p2_hit_valid (p2_hit_valid),
        .p2_hit_damage(p2_hit_damage),
        .p1_health    (p1_health),
        .p2_health    (p2_health),
        .timer_sec    (timer_sec),
        .countdown_sec(countdown_sec),
        .fight_active (fight_active),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [6:0] tim;
        logic [1:0] cd;
        logic       fa;
        logic       go;
        logic [1:0] win;
    } outs_t;

    typedef struct {
        logic [3:0] gs;
        logic       p1v;
        logic [7:0] p1d;
        logic       p2v;
        logic [7:0] p2d;
        outs_t      exp;
    } vec_t;

    localparam outs_t RESET_OUT = '{p1: 8'd100, p2: 8'd100, tim: 7'd5, cd: 2'd2,
                                   fa: 1'b0, go: 1'b0, win: 2'b00};

    vec_t  vecs[$];
    outs_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic outs_t actual();
        outs_t a;
        a = '{p1: p1_health, p2: p2_health, tim: timer_sec, cd: countdown_sec,
              fa: fight_active, go: game_over, win: winner};
        return a;
    endfunction

    task automatic compare(input string name, input outs_t act, input outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got p1=%0d p2=%0d tim=%0d cd=%0d fa=%0b go=%0b win=%0b, want p1=%0d p2=%0d tim=%0d cd=%0d fa=%0b go=%0b win=%0b",
                     name, act.p1, act.p2, act.tim, act.cd, act.fa, act.go, act.win,
                     exp.p1, exp.p2, exp.tim, exp.cd, exp.fa, exp.go, exp.win);
        end
    endtask

    task automatic add(input logic [3:0] gs, input logic p1v, input logic [7:0] p1d,
                       input logic p2v, input logic [7:0] p2d,
                       input logic [7:0] e1, input logic [7:0] e2, input logic [6:0] et,
                       input logic [1:0] ecd, input logic efa, input logic ego,
                       input logic [1:0] ew);
        vec_t v;
        v.gs  = gs;
        v.p1v = p1v;
        v.p1d = p1d;
        v.p2v = p2v;
        v.p2d = p2d;
        v.exp = '{p1: e1, p2: e2, tim: et, cd: ecd, fa: efa, go: ego, win: ew};
        vecs.push_back(v);
    endtask

    // Seconds left at fight edge k (E0 = edge 0, fight starts at edge 8).
    function automatic logic [6:0] tmr(input int k);
        return 7'(5 - (k - 8) / 4);
    endfunction

    // Edges E0..E0+8: countdown 2 -> 1 at +4 -> 0 with fight_active at +8.
    task automatic add_prefight(input logic hit3);
        for (int k = 0; k <= 8; k++) begin
            add(FIGHT_STATE, hit3 && (k == 3), 8'd50, 1'b0, 8'd0,
                8'd100, 8'd100, 7'd5,
                (k < 4) ? 2'd2 : ((k < 8) ? 2'd1 : 2'd0),
                (k == 8), 1'b0, 2'b00);
        end
    endtask

    task automatic add_quiet(input int k_from, input int k_to,
                             input logic [7:0] h1, input logic [7:0] h2);
        for (int k = k_from; k <= k_to; k++)
            add(FIGHT_STATE, 1'b0, 8'd0, 1'b0, 8'd0, h1, h2, tmr(k), 2'd0, 1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        reset         = 1'b1;
        game_state    = MAIN_MENU;
        p1_hit_valid  = 1'b0;
        p1_hit_damage = 8'd0;
        p2_hit_valid  = 1'b0;
        p2_hit_damage = 8'd0;

        // KO by four P2 hits, with a P1 hit ignored during the countdown.
        add(MAIN_MENU, 0, 0, 0, 0, 100, 100, 5, 2, 0, 0, 2'b00);
        add_prefight(1'b1);
        add(FIGHT_STATE, 0, 0, 1, 30, 100, 70, 5, 0, 1, 0, 2'b00);
        add(FIGHT_STATE, 0, 0, 0, 0, 100, 70, 5, 0, 1, 0, 2'b00);
        add(FIGHT_STATE, 0, 0, 1, 30, 100, 40, 5, 0, 1, 0, 2'b00);
        add(FIGHT_STATE, 0, 0, 1, 30, 100, 10, 4, 0, 1, 0, 2'b00);
        add(FIGHT_STATE, 0, 0, 1, 30, 100, 0, 4, 0, 0, 1, 2'b01);
        add(FIGHT_STATE, 1, 50, 1, 30, 100, 0, 4, 0, 0, 1, 2'b01);
        add(FIGHT_STATE, 0, 0, 0, 0, 100, 0, 4, 0, 0, 1, 2'b01);
        add(FIGHT_STATE, 0, 0, 0, 0, 100, 0, 4, 0, 0, 1, 2'b01);
        add(END_STATE, 0, 0, 0, 0, 100, 0, 4, 0, 0, 0, 2'b01);
        add(END_STATE, 0, 0, 0, 0, 100, 0, 4, 0, 0, 0, 2'b01);

        // Re-entry reloads; simultaneous lethal hits give a draw.
        add_prefight(1'b0);
        add(FIGHT_STATE, 1, 80, 1, 80, 20, 20, 5, 0, 1, 0, 2'b00);
        add(FIGHT_STATE, 1, 50, 1, 50, 0, 0, 5, 0, 0, 1, 2'b11);
        add(MAIN_MENU, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 2'b11);

        // Abort mid-countdown, then a full round checks the prescaler restarted.
        add(FIGHT_STATE, 0, 0, 0, 0, 100, 100, 5, 2, 0, 0, 2'b00);
        add(FIGHT_STATE, 0, 0, 0, 0, 100, 100, 5, 2, 0, 0, 2'b00);
        add(FIGHT_STATE, 0, 0, 0, 0, 100, 100, 5, 2, 0, 0, 2'b00);
        add(MAIN_MENU, 0, 0, 0, 0, 100, 100, 5, 2, 0, 0, 2'b00);
        add(MAIN_MENU, 0, 0, 0, 0, 100, 100, 5, 2, 0, 0, 2'b00);

        // Timeout with P1 behind by 10: P2 wins on the 20th fight edge.
        add_prefight(1'b0);
        add(FIGHT_STATE, 1, 10, 0, 0, 90, 100, 5, 0, 1, 0, 2'b00);
        add_quiet(10, 27, 8'd90, 8'd100);
        add(FIGHT_STATE, 0, 0, 0, 0, 90, 100, 0, 0, 0, 1, 2'b10);
        add(FIGHT_STATE, 1, 5, 0, 0, 90, 100, 0, 0, 0, 1, 2'b10);
        add(END_STATE, 0, 0, 0, 0, 90, 100, 0, 0, 0, 0, 2'b10);

        // Lethal hit on the timeout edge: KO result instead of a timeout draw.
        add_prefight(1'b0);
        add_quiet(9, 27, 8'd100, 8'd100);
        add(FIGHT_STATE, 0, 0, 1, 100, 100, 0, 0, 0, 0, 1, 2'b01);
        add(MAIN_MENU, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0, 2'b01);

        repeat (2) @(posedge clk);
        #1;
        compare("reset_values", actual(), RESET_OUT);
        reset = 1'b0;

        foreach (vecs[i]) begin
            game_state    = vecs[i].gs;
            p1_hit_valid  = vecs[i].p1v;
            p1_hit_damage = vecs[i].p1d;
            p2_hit_valid  = vecs[i].p2v;
            p2_hit_damage = vecs[i].p2d;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            compare($sformatf("vector_%0d", i), actual(), sb.pop_front());
        end

        // Asynchronous reset in the middle of a fight.
        p1_hit_valid = 1'b0;
        p2_hit_valid = 1'b0;
        game_state   = FIGHT_STATE;
        repeat (9) @(posedge clk);
        #1;
        p1_hit_valid  = 1'b1;
        p1_hit_damage = 8'd10;
        @(posedge clk);
        #1;
        p1_hit_valid = 1'b0;
        compare("mid_fight_before_reset", actual(),
                '{p1: 8'd90, p2: 8'd100, tim: 7'd5, cd: 2'd0, fa: 1'b1, go: 1'b0, win: 2'b00});
        #2;
        reset = 1'b1;
        #1;
        compare("async_reset_mid_fight", actual(), RESET_OUT);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        game_state = MAIN_MENU;
        @(posedge clk);
        #1;
        compare("idle_after_reset", actual(), RESET_OUT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fight_round_controller.md
# fight_round_controller

Runs one fight round for the two-player game: a pre-fight countdown, a round timer, and two health counters driven by hit events. It produces the `game_over` level and `winner` code. It sits directly upstream of the game state controller: it starts a round when `game_state` enters FIGHT_STATE and raises `game_over` so the controller moves to END_STATE. The health, timer and winner outputs also feed the HUD renderer.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clk cycles per game second (1 s at 100 MHz).
- `MAX_HEALTH`, default 100: starting health per player, range 1..255.
- `ROUND_SEC`, default 99: round length in seconds, range 1..127.
- `PREFIGHT_SEC`, default 3: countdown length in seconds, range 1..3.

Ports (reset is asynchronous and active-high; clock is clk):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `game_state` in 4: current game state code; FIGHT_STATE is 4'b0010.
- `p1_hit_valid` in 1: one-cycle strobe; player 1 takes damage.
- `p1_hit_damage` in 8: damage applied to player 1.
- `p2_hit_valid` in 1: one-cycle strobe; player 2 takes damage.
- `p2_hit_damage` in 8: damage applied to player 2.
- `p1_health` out 8: player 1 health.
- `p2_health` out 8: player 2 health.
- `timer_sec` out 7: round seconds remaining.
- `countdown_sec` out 2: pre-fight seconds remaining.
- `fight_active` out 1: hits are being accepted.
- `game_over` out 1: round finished.
- `winner` out 2: 00 none, 01 P1, 10 P2, 11 draw.

## Operation
States:
- IDLE (reset state).
- PREFIGHT.
- FIGHT.
- OVER.

Transitions:
- IDLE: when `game_state`==FIGHT_STATE, go to PREFIGHT.
  - Load both healths with MAX_HEALTH, `timer_sec` with ROUND_SEC, `countdown_sec` with PREFIGHT_SEC.
  - Set `winner` to 00 and clear the prescaler.
- PREFIGHT: each tick decrements `countdown_sec`. When a tick arrives with `countdown_sec`==1, set `countdown_sec` to 0 and go to FIGHT. Hits are ignored.
- FIGHT (`fight_active`=1): hits are applied, then end conditions are evaluated.
  - Health update is saturating, per player: new = (damage ≥ health) ? 0 : health − damage.
  - Simultaneous P1/P2 hits in one cycle are both applied.
  - KO, decided on the updated healths:
    - both 0: `winner`=11.
    - P2 at 0: `winner`=01.
    - P1 at 0: `winner`=10.
    - On any KO, go to OVER.
  - Timeout: on a tick with `timer_sec`==1, set `timer_sec` to 0 and go to OVER.
    - `winner` is set by comparing the updated healths: higher wins; equal gives 11.
    - KO takes priority over timeout when both happen in the same cycle.
- OVER: `game_over`=1. Healths, timer and `winner` hold; hits are ignored.
- Any state other than IDLE, when `game_state`≠FIGHT_STATE: go to IDLE.
  - `game_over`=0 and `fight_active`=0.
  - Healths, timer and `winner` hold, so the END screen can display the result.
- Damage of 0 with valid asserted is legal and has no effect.

## Timing
- Reset values:
  - IDLE; `p1_health`=`p2_health`=MAX_HEALTH; `timer_sec`=ROUND_SEC; `countdown_sec`=PREFIGHT_SEC.
  - `fight_active`=0, `game_over`=0, `winner`=00; prescaler=0.
- All outputs are registered.
- Edge E0 is the first edge that samples `game_state`==FIGHT_STATE. From E0 the state is PREFIGHT, with loads visible.
- Prescaler:
  - Counts 0..TICK_DIV−1 in PREFIGHT, FIGHT and OVER; held at 0 in IDLE.
  - Tick is asserted for the cycle where the count is TICK_DIV−1.
  - The first tick lands on edge E0+TICK_DIV.
- `fight_active` rises at edge E0+PREFIGHT_SEC·TICK_DIV.
- Hit latency: one cycle. The health update and any resulting `game_over`/`winner` appear at the edge sampling `*_hit_valid`.
- `game_over` is a level, held until `game_state` leaves FIGHT_STATE. It drops at the edge sampling the change.
- Asynchronous reset mid-round returns all outputs to reset values immediately.

## Structure
- Shared package `game_pkg` holds:
  - game state codes: MAIN_MENU 0000, CHARACTER_SELECTION 0001, FIGHT_STATE 0010, END_STATE 0011.
  - winner codes: NONE, P1, P2, DRAW.
  - widths: health 8, timer 7.
  - the fight FSM state enum.
- Sub-module `tick_prescaler`:
  - Parameter TICK_DIV.
  - Inputs clk, reset, sync `clear`; output `tick` pulse.
- The FSM, saturating subtractors and winner compare stay in this module.

## Test plan
All scenarios use TICK_DIV=4, MAX_HEALTH=100, ROUND_SEC=5, PREFIGHT_SEC=2.
- Reset is asserted mid-sim → healths 100, `timer_sec` 5, `countdown_sec` 2, `game_over` 0, `winner` 00, asynchronously.
- `game_state`=0010 at E0 → `countdown_sec` 2→1 at E0+4, then 0 with `fight_active`=1 at E0+8. A P1 hit of 50 at E0+3 leaves `p1_health`=100.
- During FIGHT, four P2 hits of 30 → `p2_health` 70, 40, 10, 0. `game_over`=1 and `winner`=01 at the fourth hit edge; further hits are ignored.
- Both at health 20, simultaneous hits of 50 each → both 0, `winner`=11, `game_over`=1.
- A single P1 hit of 10, then no hits → `timer_sec` 5→0 over 20 cycles of FIGHT, `game_over`=1, `winner`=10. A lethal hit on the timeout cycle gives a KO winner instead.
- `game_state`→0011 while OVER → `game_over`=0 next edge with `winner` held. `game_state`→0010 mid-PREFIGHT then 0000 → IDLE. Re-entering FIGHT reloads health to 100 and sets `winner`=00.
